button_event_arbiter: RTL and testbench

Converts the debounced push-button levels of the game console into single button-press events. It detects rising edges on up to N_BTN debounced inputs, holds them as pending requests, and arbitrates simultaneous presses from both players into one ordered stream. Accepted presses are queued in a small FIFO that the game-control FSM drains with a valid/ready handshake. It sits between the per-button debounce stages and the game FSM.

---
 rtl/button_event_arbiter_if.sv | 24 ++
 rtl/button_event_arbiter.sv | 81 ++++++++
 tb/tb_button_event_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/button_event_arbiter_if.sv
// button_event_arbiter_if: button levels in, press-event stream and status out.
interface button_event_arbiter_if #(
    parameter int N_BTN = 8,
    parameter int ID_W  = 3,
    parameter int CNT_W = 3
);
    logic [N_BTN-1:0] btn_db;
    logic             enable;
    logic             evt_ready;
    logic             evt_valid;
    logic [ID_W-1:0]  evt_id;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;

    modport master (
        output btn_db, enable, evt_ready,
        input  evt_valid, evt_id, evt_count, overflow
    );

    modport slave (
        input  btn_db, enable, evt_ready,
        output evt_valid, evt_id, evt_count, overflow
    );
endinterface

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: rise-edge detect, pending-request arbitration and event FIFO.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module button_event_arbiter #(
    parameter int N_BTN      = 8,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    button_event_arbiter_if.slave bus_if
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [N_BTN-1:0] btn_q, pend_q, pend_d, rise, gmask;
    logic [ID_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, full, push, pop;
    logic [ID_W-1:0]  g;

    assign rise  = bus_if.btn_db & ~btn_q;
    assign full  = cnt_q == CNT_W'(FIFO_DEPTH);
    assign push  = bus_if.enable && |pend_q && !full;
    assign pop   = bus_if.enable && cnt_q != '0 && bus_if.evt_ready;
    assign gmask = push ? N_BTN'(1) << g : '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] arb_q;

    // Descending scan so the first pending index after arb_q is the last one assigned.
    always_comb begin
        g = '0;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (pend_q[(int'(arb_q) + 1 + k) % N_BTN]) g = ID_W'((int'(arb_q) + 1 + k) % N_BTN);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)    arb_q <= ID_W'(N_BTN - 1);
        else if (push) arb_q <= g;
`else
    always_comb begin
        g = '0;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (pend_q[k]) g = ID_W'(k);
    end
`endif

    // A rise on a still-pending, ungranted bit merges into it and counts as a lost press.
    always_comb begin
        pend_d = bus_if.enable ? (pend_q & ~gmask) | rise : '0;
        ovf_d  = bus_if.enable && (ovf_q || |(rise & pend_q & ~gmask));
        cnt_d  = bus_if.enable ? cnt_q + CNT_W'(push) - CNT_W'(pop) : '0;
        wr_d   = bus_if.enable ? wr_q + PTR_W'(push) : '0;
        rd_d   = bus_if.enable ? rd_q + PTR_W'(pop) : '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            btn_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        end else begin
            btn_q  <= bus_if.btn_db;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            if (push) mem_q[wr_q] <= g;
        end

    assign bus_if.evt_valid = cnt_q != '0;
    assign bus_if.evt_id    = mem_q[rd_q];
    assign bus_if.evt_count = cnt_q;
    assign bus_if.overflow  = ovf_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: table-driven directed vectors plus reset sequences.
module tb_button_event_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_event_arbiter_if #(.N_BTN(8), .ID_W(3), .CNT_W(3)) bus ();

    button_event_arbiter #(.N_BTN(8), .ID_W(3), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus_if(bus)
    );

    typedef struct {
        logic [7:0] btn;
        logic       en;
        logic       rdy;
        logic       v;
        logic [2:0] id;
        logic [2:0] cnt;
        logic       ov;
    } vec_t;

    vec_t vecs[$];

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [2:0] FIRST = 3'd7, SECOND = 3'd0;
`else
    localparam logic [2:0] FIRST = 3'd0, SECOND = 3'd7;
`endif

    task automatic add(input logic [7:0] b, input logic e, input logic r, input logic v,
                       input logic [2:0] i, input logic [2:0] c, input logic o);
        vec_t t;
        t = '{btn: b, en: e, rdy: r, v: v, id: i, cnt: c, ov: o};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic e, input logic r);
        bus.btn_db = b;
        bus.enable = e;
        bus.evt_ready = r;
    endtask

    initial begin
        drive(8'h00, 1'b1, 1'b0);
        // single press of button 5, consumer always ready
        add(8'h20, 1, 1, 0, 0, 0, 0);
        add(8'h20, 1, 1, 1, 5, 1, 0);
        add(8'h20, 1, 1, 0, 0, 0, 0);
        add(8'h20, 1, 1, 0, 0, 0, 0);
        add(8'h20, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        // simultaneous 0x81, then repeated with pop overlapping push
        add(8'h81, 1, 0, 0, 0, 0, 0);
        add(8'h81, 1, 0, 1, FIRST, 1, 0);
        add(8'h81, 1, 0, 1, FIRST, 2, 0);
        add(8'h81, 1, 1, 1, SECOND, 1, 0);
        add(8'h81, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        add(8'h81, 1, 0, 0, 0, 0, 0);
        add(8'h81, 1, 0, 1, FIRST, 1, 0);
        add(8'h81, 1, 1, 1, SECOND, 1, 0);
        add(8'h81, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        // five presses into a four-deep queue
        add(8'h3E, 1, 0, 0, 0, 0, 0);
        add(8'h3E, 1, 0, 1, 1, 1, 0);
        add(8'h3E, 1, 0, 1, 1, 2, 0);
        add(8'h3E, 1, 0, 1, 1, 3, 0);
        add(8'h3E, 1, 0, 1, 1, 4, 0);
        add(8'h3E, 1, 0, 1, 1, 4, 0);
        add(8'h3E, 1, 0, 1, 1, 4, 0);
        add(8'h3E, 1, 1, 1, 2, 3, 0);
        add(8'h3E, 1, 0, 1, 2, 4, 0);
        add(8'h3E, 1, 1, 1, 3, 3, 0);
        add(8'h3E, 1, 1, 1, 4, 2, 0);
        add(8'h3E, 1, 1, 1, 5, 1, 0);
        add(8'h3E, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        // second press on pending button 3 while full
        add(8'h17, 1, 0, 0, 0, 0, 0);
        add(8'h17, 1, 0, 1, 0, 1, 0);
        add(8'h17, 1, 0, 1, 0, 2, 0);
        add(8'h17, 1, 0, 1, 0, 3, 0);
        add(8'h17, 1, 0, 1, 0, 4, 0);
        add(8'h1F, 1, 0, 1, 0, 4, 0);
        add(8'h17, 1, 0, 1, 0, 4, 0);
        add(8'h1F, 1, 0, 1, 0, 4, 1);
        add(8'h00, 1, 1, 1, 1, 3, 1);
        add(8'h00, 1, 1, 1, 2, 3, 1);
        add(8'h00, 1, 1, 1, 4, 2, 1);
        add(8'h00, 1, 1, 1, 3, 1, 1);
        add(8'h00, 1, 1, 0, 0, 0, 1);
        add(8'h00, 1, 0, 0, 0, 0, 1);
        add(8'h40, 1, 0, 0, 0, 0, 1);
        add(8'h40, 1, 0, 1, 6, 1, 1);
        add(8'h40, 0, 0, 0, 0, 0, 0);
        // button held across enable rising
        add(8'h04, 0, 0, 0, 0, 0, 0);
        add(8'h04, 0, 0, 0, 0, 0, 0);
        add(8'h04, 1, 0, 0, 0, 0, 0);
        add(8'h04, 1, 0, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);
        add(8'h04, 1, 0, 0, 0, 0, 0);
        add(8'h04, 1, 0, 1, 2, 1, 0);
        add(8'h04, 1, 1, 0, 0, 0, 0);
        add(8'h00, 1, 0, 0, 0, 0, 0);

        #2;
        chk("rst_valid", 0, bus.evt_valid, 0);
        chk("rst_id", 0, bus.evt_id, 0);
        chk("rst_count", 0, bus.evt_count, 0);
        chk("rst_ovf", 0, bus.overflow, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("idle_valid", i, bus.evt_valid, 0);
            chk("idle_count", i, bus.evt_count, 0);
            chk("idle_ovf", i, bus.overflow, 0);
        end

        foreach (vecs[i]) begin
            drive(vecs[i].btn, vecs[i].en, vecs[i].rdy);
            @(posedge clk);
            #1;
            chk("valid", i, bus.evt_valid, vecs[i].v);
            chk("count", i, bus.evt_count, vecs[i].cnt);
            chk("ovf", i, bus.overflow, vecs[i].ov);
            if (vecs[i].v) chk("id", i, bus.evt_id, vecs[i].id);
        end

        // asynchronous reset with an event queued and a pop in flight
        drive(8'h01, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", 0, bus.evt_valid, 1);
        chk("pre_rst_id", 0, bus.evt_id, 0);
        bus.evt_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 0, bus.evt_valid, 0);
        chk("async_rst_count", 0, bus.evt_count, 0);
        drive(8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_valid", 0, bus.evt_valid, 0);
        chk("post_rst_count", 0, bus.evt_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
